ram_port_arbiter: RTL and testbench

Two-requester controller for the team's 64×8 single-port RAM. It arbitrates with fair round-robin and sequences each access into the RAM's chip-select, read/write, address and data pins, one at a time. It returns read data and a one-cycle acknowledge to the requester that won. It sits between two client blocks and the RAM instance, and is the only driver of the RAM control pins.

---
 rtl/ram_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin two-requester front end for the 64x8 single-port RAM: one access per 3 cycles.
// Define RAM_CLEAR_EN to zero-fill the whole RAM after every reset before serving requests.
module ram_port_arbiter_lane #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ack_d_i,
  input  logic              cap_i,
  input  logic [DATA_W-1:0] dout_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] rdata_o
);
  logic              ack_q;
  logic [DATA_W-1:0] rdata_q;

  // rdata only moves on this requester's own read, so foreign accesses never disturb it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= ack_d_i;
      if (cap_i) rdata_q <= dout_i;
    end
  end

  assign ack_o   = ack_q;
  assign rdata_o = rdata_q;
endmodule

module ram_port_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              rw0_i,
  input  logic              rw1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              busy_o,
  output logic              ram_cs_o,
  output logic              ram_rw_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_din_o,
  input  logic [DATA_W-1:0] ram_dout_i
);
  localparam int NUM_REQ = 2;

`ifdef RAM_CLEAR_EN
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, CLEAR} state_e;
  localparam state_e RST_STATE = CLEAR;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  localparam state_e RST_STATE = IDLE;
`endif

  logic [NUM_REQ-1:0]             req, rw;
  logic [NUM_REQ-1:0][ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] wdata, rdata;
  logic [NUM_REQ-1:0]             ack_d, ack, cap;

  assign req   = {req1_i, req0_i};
  assign rw    = {rw1_i, rw0_i};
  assign addr  = {addr1_i, addr0_i};
  assign wdata = {wdata1_i, wdata0_i};

  state_e            state_q, state_d;
  logic              grant, win_sel;
  logic              win_q, win_d, last_q, last_d;
  logic              ram_cs_q, ram_cs_d, ram_rw_q, ram_rw_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RST_STATE;
      win_q      <= 1'b0;
      last_q     <= 1'b1;
      ram_cs_q   <= 1'b0;
      ram_rw_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      last_q     <= last_d;
      ram_cs_q   <= ram_cs_d;
      ram_rw_q   <= ram_rw_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
    end
  end

  // On a tie the requester that was not served last wins
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    win_sel = win_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant   = 1'b1;
          win_sel = (&req) ? ~last_q : req[1];
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = RESP;
      RESP:   state_d = IDLE;
`ifdef RAM_CLEAR_EN
      CLEAR:  if (ram_addr_q == '1) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_cs_d   = 1'b0;
    ram_rw_d   = ram_rw_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    win_d      = win_q;
    last_d     = last_q;
    ack_d      = '0;
    cap        = '0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          ram_cs_d   = 1'b1;
          ram_rw_d   = rw[win_sel];
          ram_addr_d = addr[win_sel];
          ram_din_d  = wdata[win_sel];
          win_d      = win_sel;
          last_d     = win_sel;
        end
      end
      ACCESS: begin
        ack_d[win_q] = 1'b1;
        cap[win_q]   = ~ram_rw_q;
      end
`ifdef RAM_CLEAR_EN
      // Address wraps back to 0 as the sweep hands over to IDLE
      CLEAR: ram_addr_d = ram_addr_q + ADDR_W'(1);
`endif
      default: ;
    endcase
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    ram_port_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .ack_d_i (ack_d[g]),
      .cap_i   (cap[g]),
      .dout_i  (ram_dout_i),
      .ack_o   (ack[g]),
      .rdata_o (rdata[g])
    );
  end

  assign ack0_o     = ack[0];
  assign ack1_o     = ack[1];
  assign rdata0_o   = rdata[0];
  assign rdata1_o   = rdata[1];
  assign busy_o     = (state_q != IDLE);
  assign ram_addr_o = ram_addr_q;
  assign ram_din_o  = ram_din_q;
`ifdef RAM_CLEAR_EN
  // The sweep strobes every cycle; din stays at its reset value of 0 throughout
  assign ram_cs_o = ram_cs_q | (state_q == CLEAR);
  assign ram_rw_o = ram_rw_q | (state_q == CLEAR);
`else
  assign ram_cs_o = ram_cs_q;
  assign ram_rw_o = ram_rw_q;
`endif
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 64x8 RAM attached to the RAM pins.
module tb_ram_port_arbiter;
`ifdef RAM_CLEAR_EN
  localparam int   CLR_CYC = 64;
  localparam logic CLR_EN  = 1'b1;
`else
  localparam int   CLR_CYC = 0;
  localparam logic CLR_EN  = 1'b0;
`endif

  logic       clk, rst;
  logic       req0, req1, rw0, rw1;
  logic [5:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, busy, ram_cs, ram_rw;
  logic [7:0] rdata0, rdata1, ram_din, ram_dout;
  logic [5:0] ram_addr;

  logic [7:0] mem [64];
  logic       pre_we;
  logic [5:0] pre_addr;
  logic [7:0] pre_data;

  int nchk = 0;
  int nfail = 0;

  ram_port_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .req1_i(req1), .rw0_i(rw0), .rw1_i(rw1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .ack0_o(ack0), .ack1_o(ack1), .rdata0_o(rdata0), .rdata1_o(rdata1),
    .busy_o(busy), .ram_cs_o(ram_cs), .ram_rw_o(ram_rw),
    .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_dout_i(ram_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_cs && ram_rw) mem[ram_addr] <= ram_din;
  end
  assign ram_dout = mem[ram_addr];

  task automatic preload(input logic [5:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (CLR_CYC) @(negedge clk);
  endtask

  // cyc = number of negedges until the ack is seen, -1 if it never comes
  task automatic wait_ack(input bit which, output int cyc);
    cyc = -1;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      if ((which ? ack1 : ack0) === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nchk++; if ({ack0, ack1} !== 2'b00) begin nfail++; $display("FAIL rst_ack got=%b exp=00", {ack0, ack1}); end
    nchk++; if ({ram_cs, ram_rw} !== {CLR_EN, CLR_EN}) begin nfail++; $display("FAIL rst_cs_rw got=%b exp=%b", {ram_cs, ram_rw}, {CLR_EN, CLR_EN}); end
    nchk++; if ({ram_addr, ram_din} !== 14'h0) begin nfail++; $display("FAIL rst_addr_din got=%h exp=0", {ram_addr, ram_din}); end
    nchk++; if ({rdata0, rdata1} !== 16'h0) begin nfail++; $display("FAIL rst_rdata got=%h exp=0", {rdata0, rdata1}); end
    nchk++; if (busy !== CLR_EN) begin nfail++; $display("FAIL rst_busy got=%b exp=%b", busy, CLR_EN); end
    repeat (CLR_CYC) @(negedge clk);
  endtask

  task automatic test_write_read();
    int c;
    do_reset();
    req0 = 1'b1; rw0 = 1'b1; addr0 = 6'h05; wdata0 = 8'hA5;
    @(negedge clk);
    nchk++; if ({ram_cs, ram_rw, ram_addr, ram_din} !== {1'b1, 1'b1, 6'h05, 8'hA5})
      begin nfail++; $display("FAIL wr_strobe got=%h exp=%h", {ram_cs, ram_rw, ram_addr, ram_din}, {1'b1, 1'b1, 6'h05, 8'hA5}); end
    nchk++; if ({ack0, busy} !== 2'b01) begin nfail++; $display("FAIL wr_k1_ack_busy got=%b exp=01", {ack0, busy}); end
    @(negedge clk);
    nchk++; if ({ack0, ack1, ram_cs} !== 3'b100) begin nfail++; $display("FAIL wr_k2_ack got=%b exp=100", {ack0, ack1, ram_cs}); end
    req0 = 1'b0;
    @(negedge clk);
    nchk++; if ({ack0, busy} !== 2'b00) begin nfail++; $display("FAIL wr_k3_idle got=%b exp=00", {ack0, busy}); end
    nchk++; if (mem[5] !== 8'hA5) begin nfail++; $display("FAIL wr_mem got=%h exp=a5", mem[5]); end
    req0 = 1'b1; rw0 = 1'b0;
    wait_ack(1'b0, c);
    nchk++; if (c !== 2) begin nfail++; $display("FAIL rd_latency got=%0d exp=2", c); end
    nchk++; if (rdata0 !== 8'hA5) begin nfail++; $display("FAIL rd_rdata0 got=%h exp=a5", rdata0); end
    nchk++; if ({ack1, rdata1} !== 9'h0) begin nfail++; $display("FAIL rd_other got=%h exp=0", {ack1, rdata1}); end
    req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    int c;
    logic [5:0] a0 [2];
    logic [5:0] a1 [2];
    logic [7:0] e0 [2];
    logic [7:0] e1 [2];
    int lat0 [2];
    a0 = '{6'h10, 6'h11}; a1 = '{6'h20, 6'h21};
    e0 = '{8'h3C, 8'h5A}; e1 = '{8'hC3, 8'h96};
    lat0 = '{2, 3};
    do_reset();
    rw0 = 1'b0; rw1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req0 = 1'b1; req1 = 1'b1; addr0 = a0[i]; addr1 = a1[i];
      wait_ack(1'b0, c);
      nchk++; if (c !== lat0[i]) begin nfail++; $display("FAIL cont_ack0_lat[%0d] got=%0d exp=%0d", i, c, lat0[i]); end
      nchk++; if ({ack1, rdata0} !== {1'b0, e0[i]}) begin nfail++; $display("FAIL cont_rdata0[%0d] got=%h exp=%h", i, {ack1, rdata0}, {1'b0, e0[i]}); end
      req0 = 1'b0;
      wait_ack(1'b1, c);
      nchk++; if (c !== 3) begin nfail++; $display("FAIL cont_ack1_gap[%0d] got=%0d exp=3", i, c); end
      nchk++; if ({ack0, rdata1} !== {1'b0, e1[i]}) begin nfail++; $display("FAIL cont_rdata1[%0d] got=%h exp=%h", i, {ack0, rdata1}, {1'b0, e1[i]}); end
      req1 = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_held_loser();
    int c;
    do_reset();
    req0 = 1'b1; rw0 = 1'b0; addr0 = 6'h10;
    @(negedge clk);
    req1 = 1'b1; rw1 = 1'b1; addr1 = 6'h30; wdata1 = 8'h77;
    wait_ack(1'b0, c);
    nchk++; if (c !== 1) begin nfail++; $display("FAIL held_ack0 got=%0d exp=1", c); end
    nchk++; if (rdata0 !== 8'h3C) begin nfail++; $display("FAIL held_rdata0 got=%h exp=3c", rdata0); end
    req0 = 1'b0;
    wait_ack(1'b1, c);
    nchk++; if (c !== 3) begin nfail++; $display("FAIL held_ack1_gap got=%0d exp=3", c); end
    req1 = 1'b0;
    @(negedge clk);
    nchk++; if ({mem[6'h30], rdata0} !== 16'h773C) begin nfail++; $display("FAIL held_mem_rdata0 got=%h exp=773c", {mem[6'h30], rdata0}); end
  endtask

  task automatic test_back_to_back();
    int c;
    do_reset();
    req0 = 1'b1; rw0 = 1'b0; addr0 = 6'h11;
    wait_ack(1'b0, c);
    nchk++; if ({c[7:0], rdata0} !== {8'd2, 8'h5A}) begin nfail++; $display("FAIL b2b_first got=%0d/%h exp=2/5a", c, rdata0); end
    addr0 = 6'h21;
    wait_ack(1'b0, c);
    nchk++; if ({c[7:0], rdata0} !== {8'd3, 8'h96}) begin nfail++; $display("FAIL b2b_second got=%0d/%h exp=3/96", c, rdata0); end
    req0 = 1'b0;
    @(negedge clk);
    nchk++; if ({ack0, busy} !== 2'b00) begin nfail++; $display("FAIL b2b_idle got=%b exp=00", {ack0, busy}); end
    repeat (2) @(negedge clk);
    nchk++; if ({ack0, busy, rdata0} !== {2'b00, 8'h96}) begin nfail++; $display("FAIL b2b_no_dup got=%h exp=096", {ack0, busy, rdata0}); end
  endtask

  task automatic test_reset_in_access();
    int c;
    do_reset();
    req0 = 1'b1; rw0 = 1'b1; addr0 = 6'h3F; wdata0 = 8'hEE;
    @(negedge clk);
    nchk++; if (ram_cs !== 1'b1) begin nfail++; $display("FAIL ria_access_cs got=%b exp=1", ram_cs); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nchk++; if ({ack0, ack1, ram_cs, ram_rw, busy} !== {2'b00, CLR_EN, CLR_EN, CLR_EN})
      begin nfail++; $display("FAIL ria_ctrl got=%b exp=%b", {ack0, ack1, ram_cs, ram_rw, busy}, {2'b00, CLR_EN, CLR_EN, CLR_EN}); end
    nchk++; if ({ram_addr, ram_din, rdata0, rdata1} !== 30'h0) begin nfail++; $display("FAIL ria_data got=%h exp=0", {ram_addr, ram_din, rdata0, rdata1}); end
    req1 = 1'b1; rw1 = 1'b0; addr1 = 6'h20;
    wait_ack(1'b0, c);
    nchk++; if ({c, ack1} !== {CLR_CYC + 2, 1'b0}) begin nfail++; $display("FAIL ria_first_grant got=%0d/%b exp=%0d/0", c, ack1, CLR_CYC + 2); end
    req0 = 1'b0;
    wait_ack(1'b1, c);
    nchk++; if ({c[7:0], rdata1} !== {8'd3, 8'hC3}) begin nfail++; $display("FAIL ria_second got=%0d/%h exp=3/c3", c, rdata1); end
    req1 = 1'b0;
    @(negedge clk);
  endtask

`ifdef RAM_CLEAR_EN
  task automatic test_clear();
    int c;
    preload(6'h00, 8'hFF);
    preload(6'h3F, 8'hFF);
    rst = 1'b1; req0 = 1'b1; rw0 = 1'b0; addr0 = 6'h00;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i > 0) @(negedge clk);
      nchk++; if ({busy, ram_cs, ram_rw, ram_din, ram_addr} !== {3'b111, 8'h00, 6'(i)})
        begin nfail++; $display("FAIL clr_sweep[%0d] got=%h exp=%h", i, {busy, ram_cs, ram_rw, ram_din, ram_addr}, {3'b111, 8'h00, 6'(i)}); end
    end
    wait_ack(1'b0, c);
    nchk++; if ({c[7:0], rdata0} !== {8'd3, 8'h00}) begin nfail++; $display("FAIL clr_rd0 got=%0d/%h exp=3/00", c, rdata0); end
    addr0 = 6'h3F;
    wait_ack(1'b0, c);
    nchk++; if ({c[7:0], rdata0} !== {8'd3, 8'h00}) begin nfail++; $display("FAIL clr_rd3f got=%0d/%h exp=3/00", c, rdata0); end
    req0 = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    rst = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    req0 = 1'b0; req1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    @(negedge clk);
    preload(6'h10, 8'h3C);
    preload(6'h11, 8'h5A);
    preload(6'h20, 8'hC3);
    preload(6'h21, 8'h96);
    test_reset();
    test_write_read();
    test_contention();
    test_held_loser();
    test_back_to_back();
    test_reset_in_access();
`ifdef RAM_CLEAR_EN
    test_clear();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
